// File: rtl/mic_tdoa_direction.sv
// mic_tdoa_direction
//   Measures the signed time difference of arrival (in CLK cycles) between
//   rising edges of the right and left microphone comparator outputs,
//   averages 2^AVG_LOG2 measurements and reports the averaged lag, the
//   closer side and a centred flag, qualified by a one-cycle Valid strobe.
//
// Optional build macro: MIC_DIR_HYST_EN
//   defined   : Direction flips only after HYST_COUNT consecutive non-centred
//               results on the side opposite the current Direction.
//   undefined : Direction follows every non-centred result immediately.
//
// Ports
//   CLK       in   system clock
//   RST       in   asynchronous active-high reset
//   RightMic  in   asynchronous right mic comparator output
//   LeftMic   in   asynchronous left mic comparator output
//   Lag       out  signed averaged lag (CNT_W+1 bits), positive = right first
//   Direction out  1 = right mic closer, 0 = left mic closer (held while centred)
//   Centered  out  last averaged |Lag| <= DEADBAND
//   Valid     out  one-cycle strobe when Lag/Direction/Centered update
//   Timeout   out  one-cycle strobe when a measurement is abandoned
module mic_tdoa_direction #(
  parameter int CNT_W      = 12,
  parameter int TIMEOUT    = 2000,
  parameter int AVG_LOG2   = 2,
  parameter int DEADBAND   = 2,
  parameter int HYST_COUNT = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RightMic,
  input  logic         LeftMic,
  output logic [CNT_W:0] Lag,
  output logic         Direction,
  output logic         Centered,
  output logic         Valid,
  output logic         Timeout
);

  localparam int ACC_W = CNT_W + 1 + AVG_LOG2;
  // Sample counter needs at least one bit even when no averaging is done.
  localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM_R = 2'd1;
  localparam logic [1:0] ST_ARM_L = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic signed [CNT_W:0] DB_P = (CNT_W+1)'(DEADBAND);
  localparam logic signed [CNT_W:0] DB_N = -DB_P;

  logic                     r_r_meta, r_r_sync, r_r_prev;
  logic                     r_l_meta, r_l_sync, r_l_prev;
  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [CNT_W:0]    r_sample;
  logic signed [ACC_W-1:0]  r_acc;
  logic [SC_W-1:0]          r_scnt;
  logic signed [CNT_W:0]    r_lag;
  logic                     r_dir, r_cent, r_valid, r_tout;

  logic                     w_r_edge, w_l_edge;
  logic [1:0]               w_state_nx;
  logic [CNT_W-1:0]         w_cnt_nx, w_inc;
  logic signed [CNT_W:0]    w_sample_nx;
  logic                     w_tout_nx;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [CNT_W:0]    w_lag_new;
  logic                     w_cent_new, w_pos, w_dir_new;

  // Two-flop synchronisers plus a delayed copy for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_r_meta <= 1'b0; r_r_sync <= 1'b0; r_r_prev <= 1'b0;
      r_l_meta <= 1'b0; r_l_sync <= 1'b0; r_l_prev <= 1'b0;
    end else begin
      r_r_meta <= RightMic; r_r_sync <= r_r_meta; r_r_prev <= r_r_sync;
      r_l_meta <= LeftMic;  r_l_sync <= r_l_meta; r_l_prev <= r_l_sync;
    end
  end

  assign w_r_edge = r_r_sync & ~r_r_prev;
  assign w_l_edge = r_l_sync & ~r_l_prev;
  assign w_inc    = r_cnt + CNT_W'(1);

  // Measurement FSM next-state logic.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_sample_nx = r_sample;
    w_tout_nx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_r_edge && w_l_edge) begin
          w_sample_nx = '0;
          w_state_nx  = ST_DONE;
        end else if (w_r_edge) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_ARM_R;
        end else if (w_l_edge) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_ARM_L;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_ARM_R, ST_ARM_L: begin
        // Opposite edge wins over a same-channel re-trigger in the same cycle.
        if ((r_state == ST_ARM_R) ? w_l_edge : w_r_edge) begin
          w_sample_nx = (r_state == ST_ARM_R) ? $signed({1'b0, w_inc})
                                              : -$signed({1'b0, w_inc});
          w_state_nx  = ST_DONE;
        end else if ((r_state == ST_ARM_R) ? w_r_edge : w_l_edge) begin
          w_cnt_nx = '0;
        end else if (w_inc == CNT_W'(TIMEOUT)) begin
          w_tout_nx  = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_cnt_nx = w_inc;
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Averaged result computed from the window including the current sample.
  always_comb begin
    w_acc_sum  = r_acc + ACC_W'(r_sample);
    w_lag_new  = (CNT_W+1)'(w_acc_sum >>> AVG_LOG2);
    w_cent_new = (w_lag_new <= DB_P) && (w_lag_new >= DB_N);
    w_pos      = ~w_lag_new[CNT_W] && (w_lag_new != '0);
  end

`ifdef MIC_DIR_HYST_EN
  localparam int HS_W = $clog2(HYST_COUNT + 1);
  logic [HS_W-1:0] r_streak;
  logic [HS_W-1:0] w_streak_new;

  // Direction hysteresis: count consecutive opposite-side results.
  always_comb begin
    w_dir_new    = r_dir;
    w_streak_new = r_streak;
    if (!w_cent_new) begin
      if (w_pos != r_dir) begin
        if ((r_streak + HS_W'(1)) >= HS_W'(HYST_COUNT)) begin
          w_dir_new    = w_pos;
          w_streak_new = '0;
        end else begin
          w_streak_new = r_streak + HS_W'(1);
        end
      end else begin
        w_streak_new = '0;
      end
    end else begin
      w_streak_new = r_streak;
    end
  end

  // Streak register advances only when a result is published.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_streak <= '0;
    end else if ((r_state == ST_DONE) && (r_scnt == SC_W'(NSAMP - 1))) begin
      r_streak <= w_streak_new;
    end
  end
`else
  // Direction follows every non-centred result.
  always_comb begin
    w_dir_new = w_cent_new ? r_dir : w_pos;
  end
`endif

  // FSM, counter, accumulator and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sample <= '0;
      r_acc    <= '0;
      r_scnt   <= '0;
      r_lag    <= '0;
      r_dir    <= 1'b0;
      r_cent   <= 1'b0;
      r_valid  <= 1'b0;
      r_tout   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_sample <= w_sample_nx;
      r_tout   <= w_tout_nx;
      r_valid  <= 1'b0;
      if (r_state == ST_DONE) begin
        if (r_scnt == SC_W'(NSAMP - 1)) begin
          r_acc   <= '0;
          r_scnt  <= '0;
          r_lag   <= w_lag_new;
          r_cent  <= w_cent_new;
          r_dir   <= w_dir_new;
          r_valid <= 1'b1;
        end else begin
          r_acc  <= w_acc_sum;
          r_scnt <= r_scnt + SC_W'(1);
        end
      end
    end
  end

  assign Lag       = r_lag;
  assign Direction = r_dir;
  assign Centered  = r_cent;
  assign Valid     = r_valid;
  assign Timeout   = r_tout;

endmodule

// File: tb/tb_mic_tdoa_direction.sv
module tb_mic_tdoa_direction;

  localparam int CNT_W = 12;
  localparam int T     = 2000;
  localparam int AVGL  = 2;
  localparam int NAVG  = 1 << AVGL;
  localparam int DB    = 2;
  localparam int HYST  = 3;

  logic CLK = 1'b0;
  logic RST;
  logic RightMic, LeftMic;
  logic [CNT_W:0] Lag;
  logic Direction, Centered, Valid, Timeout;

  mic_tdoa_direction #(.CNT_W(CNT_W), .TIMEOUT(T), .AVG_LOG2(AVGL),
                       .DEADBAND(DB), .HYST_COUNT(HYST)) dut (
    .CLK(CLK), .RST(RST), .RightMic(RightMic), .LeftMic(LeftMic),
    .Lag(Lag), .Direction(Direction), .Centered(Centered),
    .Valid(Valid), .Timeout(Timeout));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit is_valid;
    int cyc;
    int lag;
    bit dir;
    bit cent;
  } ev_t;
  ev_t q[$];

  // Model state: partial window and published direction
  int m_sum = 0;
  int m_n = 0;
  bit m_dir = 1'b0;
  int m_streak = 0;
  // Values the outputs must hold
  int h_lag = 0;
  bit h_dir = 1'b0;
  bit h_cent = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int n);
    int r;
    r = s / n;
    if ((s % n != 0) && (s < 0)) r = r - 1;
    return r;
  endfunction

  // One matched measurement of lag s whose second edge is driven at cycle cb
  task automatic add_sample(input int s, input int cb);
    int lag;
    bit cent, side;
    ev_t e;
    m_sum += s;
    m_n++;
    if (m_n == NAVG) begin
      lag  = floor_div(m_sum, NAVG);
      cent = (lag <= DB) && (lag >= -DB);
      side = (lag > 0);
      if (!cent) begin
`ifdef MIC_DIR_HYST_EN
        if (side != m_dir) begin
          m_streak++;
          if (m_streak >= HYST) begin
            m_dir = side;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
`else
        m_dir = side;
`endif
      end
      e.is_valid = 1'b1; e.cyc = cb + 4; e.lag = lag; e.dir = m_dir; e.cent = cent;
      q.push_back(e);
      m_sum = 0;
      m_n = 0;
    end
  endtask

  // Pulse pair: d > 0 right leads by d cycles, d < 0 left leads by -d
  task automatic pair(input int d);
    int a, c0;
    a = (d < 0) ? -d : d;
    c0 = cyc;
    for (int k = 0; k <= a + 10; k++) begin
      if (d >= 0) begin
        RightMic = (k < 3);
        LeftMic  = (k >= a) && (k < a + 3);
      end else begin
        LeftMic  = (k < 3);
        RightMic = (k >= a) && (k < a + 3);
      end
      if (k == 0) add_sample(d, c0 + a);
      @(negedge CLK);
    end
  endtask

  // Unmatched pulses on one mic; the last one must be abandoned
  task automatic lone(input bit right, input int n, input int sp);
    int c0, total;
    ev_t e;
    bit hi;
    c0 = cyc;
    total = (n - 1) * sp + T + 10;
    e.is_valid = 1'b0; e.cyc = c0 + (n - 1) * sp + T + 3;
    e.lag = 0; e.dir = 1'b0; e.cent = 1'b0;
    q.push_back(e);
    for (int k = 0; k <= total; k++) begin
      hi = (k < n * sp) && ((k % sp) < 3);
      RightMic = right & hi;
      LeftMic  = ~right & hi;
      @(negedge CLK);
    end
  endtask

  // Compare process: strobes, timing and held output values every cycle
  always @(negedge CLK) begin
    bit exp_v, exp_t;
    if (RST === 1'b1) begin
      h_lag = 0; h_dir = 1'b0; h_cent = 1'b0;
      chk("reset_lag", int'($signed(Lag)), 0);
      chk("reset_dir", int'(Direction), 0);
      chk("reset_cent", int'(Centered), 0);
      chk("reset_valid", int'(Valid), 0);
      chk("reset_timeout", int'(Timeout), 0);
    end else begin
      exp_v = 1'b0;
      exp_t = 1'b0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event at cycle %0d: expected strobe at cycle %0d not seen", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        if (q[0].is_valid) begin
          exp_v = 1'b1;
          h_lag = q[0].lag; h_dir = q[0].dir; h_cent = q[0].cent;
        end else begin
          exp_t = 1'b1;
        end
        void'(q.pop_front());
      end
      chk("valid", int'(Valid), int'(exp_v));
      chk("timeout", int'(Timeout), int'(exp_t));
      chk("lag", int'($signed(Lag)), h_lag);
      chk("direction", int'(Direction), int'(h_dir));
      chk("centered", int'(Centered), int'(h_cent));
    end
  end

  task automatic model_reset();
    q.delete();
    m_sum = 0; m_n = 0; m_dir = 1'b0; m_streak = 0;
  endtask

  int hyst_exp[6];
  int hyst_lag[6];

  initial begin
    RST = 1'b1;
    RightMic = 1'b0;
    LeftMic = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);

    // Right leads by 10
    repeat (4) pair(10);
    chk("lit_lag_p10", int'($signed(Lag)), 10);
    chk("lit_cent_p10", int'(Centered), 0);
`ifndef MIC_DIR_HYST_EN
    chk("lit_dir_p10", int'(Direction), 1);
`endif
    // Simultaneous edges: centred, direction held
    repeat (4) pair(0);
    chk("lit_lag_zero", int'($signed(Lag)), 0);
    chk("lit_cent_zero", int'(Centered), 1);
`ifndef MIC_DIR_HYST_EN
    chk("lit_dir_zero", int'(Direction), 1);
`endif
    // Left leads by 7
    repeat (4) pair(-7);
    chk("lit_lag_m7", int'($signed(Lag)), -7);
    chk("lit_cent_m7", int'(Centered), 0);
`ifndef MIC_DIR_HYST_EN
    chk("lit_dir_m7", int'(Direction), 0);
`endif
    // Mixed window averaging to +1 (centred)
    pair(3); pair(3); pair(-1); pair(-1);
    chk("lit_lag_mix", int'($signed(Lag)), 1);
    chk("lit_cent_mix", int'(Centered), 1);
    // Left-only pulses: restart then abandon
    lone(1'b0, 3, 100);

    // Reset while right edge is pending
    RightMic = 1'b1;
    repeat (3) @(negedge CLK);
    RightMic = 1'b0;
    repeat (20) @(negedge CLK);
    #2 RST = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    repeat (4) pair(20);
    chk("lit_lag_p20", int'($signed(Lag)), 20);
`ifndef MIC_DIR_HYST_EN
    chk("lit_dir_p20", int'(Direction), 1);
`endif

    // Establish Direction = 1, then opposite-side sequence
    for (int i = 0; i < 4 && !m_dir; i++) repeat (4) pair(20);
    chk("lit_dir_before_seq", int'(Direction), 1);
    hyst_lag = '{-10, -10, 10, -10, -10, -10};
`ifdef MIC_DIR_HYST_EN
    hyst_exp = '{1, 1, 1, 1, 1, 0};
`else
    hyst_exp = '{0, 0, 1, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++) begin
      repeat (4) pair(hyst_lag[i]);
      chk("lit_dir_seq", int'(Direction), hyst_exp[i]);
      chk("lit_lag_seq", int'($signed(Lag)), hyst_lag[i]);
    end

    // Randomised trials
    for (int t = 0; t < 48; t++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 7) begin
        lone(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), int'($urandom_range(6, 200)));
      end else if (r < 12) begin
        pair(($urandom_range(0, 1) != 0) ? T : -T);
      end else begin
        pair(int'($urandom_range(0, 120)) - 60);
      end
    end

    repeat (10) @(negedge CLK);
    chk("pending_events", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
